dmi_jtag_initiator: RTL and testbench
=====================================

# dmi_jtag_initiator

DTM-side Debug Module Interface (DMI) initiator: the requesting end of the `dm::dmi_req_t` / `dm::dmi_resp_t` link that the debug module consumes. It converts DMI scan-register update and capture strobes, produced by a JTAG TAP/shift block already synchronised into `clk_i`, into valid/ready request transactions. It collects the responses and maintains the sticky `dmistat` error state reported through `dtmcs`. It sits between the TAP data-register logic and the debug module's DMI port.

## Interface
- No parameters; widths are fixed by the DMI protocol: 7-bit address, 2-bit op, 32-bit data.
- Clocking and reset (already decided): one clock, `clk_i`; reset `rst_ni` is asynchronous and active-low.

Ports (name, direction, width, meaning):
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `dmi_update_i` in 1: one-cycle Update-DR strobe for the DMI register.
- `dmi_capture_i` in 1: one-cycle Capture-DR strobe for the DMI register.
- `dmi_wdata_i` in 41: scanned-in word laid out as {addr[40:34], data[33:2], op[1:0]}.
- `dmi_rdata_o` out 41: capture value laid out as {addr_q, data_q, status}.
- `dmireset_i` in 1: `dtmcs.dmireset` pulse; clears the sticky error.
- `dmihardreset_i` in 1: `dtmcs.dmihardreset` pulse; aborts the transaction and clears the error.
- `dmistat_o` out 2: current sticky error, for `dtmcs`.
- `dmi_rst_no` out 1: active-low DMI-link reset to the debug module.
- `dmi_req_o` out 41: `dm::dmi_req_t`, packed {addr, op, data}.
- `dmi_req_valid_o` out 1: request valid.
- `dmi_req_ready_i` in 1: request ready.
- `dmi_resp_i` in 34: `dm::dmi_resp_t`, packed {data, resp}.
- `dmi_resp_valid_i` in 1: response valid.
- `dmi_resp_ready_o` out 1: response ready.

## Operation
- Registers:
  - `addr_q[6:0]`, `data_q[31:0]`.
  - `error_q[1:0]`: 0 = success, 2 = failed, 3 = busy.
  - FSM with states `Idle`, `Read`, `WaitRead`, `Write`, `WaitWrite`.
- Field repacking: scan order is {addr, data, op}; request order is {addr, op, data}. This must be repacked explicitly, not bit-copied.
- `Idle`, `dmi_update_i` with `error_q == 0`:
  - op = `DTM_READ`: latch addr and go to `Read`.
  - op = `DTM_WRITE`: latch addr and data, and go to `Write`.
  - op = `DTM_NOP` or 3: no request; `addr_q` and `data_q` unchanged.
- `dmi_update_i` with `error_q != 0`: ignored entirely, with no request and no register change.
- `Read` / `Write`:
  - `dmi_req_valid_o = 1`.
  - `dmi_req_o = {addr_q, DTM_READ or DTM_WRITE, data_q}`; for a read, the data field is 0.
  - Valid and payload are held stable until `dmi_req_ready_i`.
  - On handshake, go to `WaitRead` / `WaitWrite`.
- `WaitRead` / `WaitWrite`:
  - `dmi_resp_ready_o = 1`.
  - On `dmi_resp_valid_i`, return to `Idle`.
  - Read: `data_q <= dmi_resp_i.data`.
  - Write: response data is discarded.
  - If `resp != DTM_SUCCESS` and `error_q == 0`, set `error_q <= 2`.
- Busy detection: when FSM is not `Idle`, a `dmi_update_i` or `dmi_capture_i` sets `error_q <= 3` if `error_q == 0`. An update in that case issues no request.
- Status output:
  - `dmi_rdata_o[1:0] = (FSM != Idle) ? 3 : error_q`.
  - `dmi_rdata_o[40:2] = {addr_q, data_q}`.
  - `dmistat_o = error_q`.
- `dmireset_i`: `error_q <= 0`; FSM and transaction are unaffected.
- `dmihardreset_i`:
  - `error_q <= 0`, FSM to `Idle`, valid and ready drop next cycle.
  - `dmi_rst_no` is driven low for exactly one cycle, so the debug module flushes the abandoned transaction.
- Simultaneous events:
  - `dmihardreset_i` overrides everything.
  - `dmireset_i` is applied before the update in the same cycle, so an update is then evaluated with `error_q == 0`.
  - Update and capture in the same cycle: update is processed, capture ignored.
  - A response error and busy in the same cycle: busy (3) wins.
- Reset values: FSM `Idle`, all registers 0, `dmi_req_valid_o = 0`, `dmi_resp_ready_o = 0`, `dmi_rdata_o = 0`, `dmistat_o = 0`, `dmi_rst_no = 1`.

## Timing
- Request issue: update at edge N gives `dmi_req_valid_o = 1` from cycle N+1. With ready held high, the request handshake completes in N+1.
- Response collection: `dmi_resp_ready_o` is high from the cycle after the request handshake. `data_q` updates and the FSM reaches `Idle` on the response-handshake edge.
- Minimum round trip is 3 cycles from update to `Idle` when the responder answers in the cycle after accepting.
- No combinational path from `*_ready_i` or `*_valid_i` to any output.
- Status latency: `error_q` and `dmistat_o` change one cycle after the causing strobe or response.
- `dmi_rdata_o[1:0]` reflects FSM state combinationally from registers.

## Test plan
- Read: update {addr 0x11, op 1}; responder returns data 0xDEADBEEF, resp 0. Required: one request {0x11, READ, 0}; a later capture reads {0x11, 0xDEADBEEF, 0}.
- Write with backpressure: update {addr 0x04, data 0x12345678, op 2}; ready held low 5 cycles. Required: valid and payload stable for all 5 cycles; exactly one handshake; `dmistat_o = 0`.
- Busy: capture and then a second update while in `WaitRead`. Required: capture sees status 3; `error_q = 3`; no second request; a later update is ignored until `dmireset_i`, after which it issues normally.
- Failed response: a write returns resp 2. Required: `dmistat_o = 2`; a subsequent update produces no request.
- Hard reset while `Write` is stalled on ready: pulse `dmihardreset_i`. Required: valid low the next cycle; `dmi_rst_no` low for exactly 1 cycle; `error_q = 0`; FSM `Idle`.
- Async reset mid-transaction: drop `rst_ni` during `WaitRead`. Required: all outputs go to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dmi_jtag_initiator.sv
// DTM-side DMI initiator: turns synchronised Update-DR/Capture-DR strobes into
// valid/ready DMI requests, collects responses and keeps the sticky dmistat error.
module dmi_jtag_initiator (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dmi_update_i,
    input  logic        dmi_capture_i,
    input  logic [40:0] dmi_wdata_i,
    output logic [40:0] dmi_rdata_o,
    input  logic        dmireset_i,
    input  logic        dmihardreset_i,
    output logic [1:0]  dmistat_o,
    output logic        dmi_rst_no,
    output logic [40:0] dmi_req_o,
    output logic        dmi_req_valid_o,
    input  logic        dmi_req_ready_i,
    input  logic [33:0] dmi_resp_i,
    input  logic        dmi_resp_valid_i,
    output logic        dmi_resp_ready_o
);

    localparam int unsigned AddrW = 7;
    localparam int unsigned DataW = 32;
    localparam int unsigned OpW   = 2;

    localparam logic [OpW-1:0] DtmNop     = 2'd0;
    localparam logic [OpW-1:0] DtmRead    = 2'd1;
    localparam logic [OpW-1:0] DtmWrite   = 2'd2;
    localparam logic [OpW-1:0] DtmSuccess = 2'd0;
    localparam logic [1:0]     ErrNone    = 2'd0;
    localparam logic [1:0]     ErrFailed  = 2'd2;
    localparam logic [1:0]     ErrBusy    = 2'd3;

    typedef enum logic [2:0] {
        Idle,
        Read,
        WaitRead,
        Write,
        WaitWrite
    } state_e;

    state_e             state_q;
    logic [AddrW-1:0]   addr_q;
    logic [DataW-1:0]   data_q;
    logic [1:0]         error_q;
    logic               req_valid_q;
    logic               resp_ready_q;
    logic               dmi_rst_n_q;

    // Scan order is {addr, data, op}; the request uses {addr, op, data}.
    logic [AddrW-1:0]   scan_addr;
    logic [DataW-1:0]   scan_data;
    logic [OpW-1:0]     scan_op;
    logic [DataW-1:0]   resp_data;
    logic [OpW-1:0]     resp_code;

    assign scan_addr = dmi_wdata_i[40:34];
    assign scan_data = dmi_wdata_i[33:2];
    assign scan_op   = dmi_wdata_i[1:0];
    assign resp_data = dmi_resp_i[33:2];
    assign resp_code = dmi_resp_i[1:0];

    // dmireset takes effect before anything else evaluated in the same cycle.
    logic [1:0] error_base;
    always_comb begin
        error_base = error_q;
        if (dmireset_i) begin
            error_base = ErrNone;
        end
    end

    logic [OpW-1:0]   req_op;
    logic [DataW-1:0] req_data;
    always_comb begin
        req_op   = DtmNop;
        req_data = '0;
        if (state_q == Read) begin
            req_op = DtmRead;
        end else if (state_q == Write) begin
            req_op   = DtmWrite;
            req_data = data_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= Idle;
            addr_q       <= '0;
            data_q       <= '0;
            error_q      <= ErrNone;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b0;
            dmi_rst_n_q  <= 1'b1;
        end else if (dmihardreset_i) begin
            state_q      <= Idle;
            error_q      <= ErrNone;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b0;
            dmi_rst_n_q  <= 1'b0;
        end else begin
            dmi_rst_n_q <= 1'b1;
            error_q     <= error_base;
            case (state_q)
                Idle: begin
                    if (dmi_update_i && (error_base == ErrNone)) begin
                        if (scan_op == DtmRead) begin
                            addr_q      <= scan_addr;
                            state_q     <= Read;
                            req_valid_q <= 1'b1;
                        end else if (scan_op == DtmWrite) begin
                            addr_q      <= scan_addr;
                            data_q      <= scan_data;
                            state_q     <= Write;
                            req_valid_q <= 1'b1;
                        end
                    end
                end
                Read, Write: begin
                    if (dmi_req_ready_i) begin
                        state_q      <= (state_q == Read) ? WaitRead : WaitWrite;
                        req_valid_q  <= 1'b0;
                        resp_ready_q <= 1'b1;
                    end
                end
                WaitRead, WaitWrite: begin
                    if (dmi_resp_valid_i) begin
                        state_q      <= Idle;
                        resp_ready_q <= 1'b0;
                        if (state_q == WaitRead) begin
                            data_q <= resp_data;
                        end
                        if ((resp_code != DtmSuccess) && (error_base == ErrNone)) begin
                            error_q <= ErrFailed;
                        end
                    end
                end
                default: begin
                    state_q      <= Idle;
                    req_valid_q  <= 1'b0;
                    resp_ready_q <= 1'b0;
                end
            endcase
            // Busy overrides a simultaneous failed response.
            if ((state_q != Idle) && (dmi_update_i || dmi_capture_i) && (error_base == ErrNone)) begin
                error_q <= ErrBusy;
            end
        end
    end

    assign dmi_req_o        = {addr_q, req_op, req_data};
    assign dmi_req_valid_o  = req_valid_q;
    assign dmi_resp_ready_o = resp_ready_q;
    assign dmi_rst_no       = dmi_rst_n_q;
    assign dmistat_o        = error_q;
    assign dmi_rdata_o      = {addr_q, data_q, (state_q != Idle) ? ErrBusy : error_q};

endmodule

// File: tb/tb_dmi_jtag_initiator.sv
// Directed self-checking bench for dmi_jtag_initiator.
module tb_dmi_jtag_initiator;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        dmi_update_i;
    logic        dmi_capture_i;
    logic [40:0] dmi_wdata_i;
    logic [40:0] dmi_rdata_o;
    logic        dmireset_i;
    logic        dmihardreset_i;
    logic [1:0]  dmistat_o;
    logic        dmi_rst_no;
    logic [40:0] dmi_req_o;
    logic        dmi_req_valid_o;
    logic        dmi_req_ready_i;
    logic [33:0] dmi_resp_i;
    logic        dmi_resp_valid_i;
    logic        dmi_resp_ready_o;

    int total = 0;
    int bad   = 0;
    int req_cnt = 0;
    logic [40:0] last_req = '0;

    dmi_jtag_initiator dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .dmi_update_i     (dmi_update_i),
        .dmi_capture_i    (dmi_capture_i),
        .dmi_wdata_i      (dmi_wdata_i),
        .dmi_rdata_o      (dmi_rdata_o),
        .dmireset_i       (dmireset_i),
        .dmihardreset_i   (dmihardreset_i),
        .dmistat_o        (dmistat_o),
        .dmi_rst_no       (dmi_rst_no),
        .dmi_req_o        (dmi_req_o),
        .dmi_req_valid_o  (dmi_req_valid_o),
        .dmi_req_ready_i  (dmi_req_ready_i),
        .dmi_resp_i       (dmi_resp_i),
        .dmi_resp_valid_i (dmi_resp_valid_i),
        .dmi_resp_ready_o (dmi_resp_ready_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (dmi_req_valid_o && dmi_req_ready_i) begin
            req_cnt  = req_cnt + 1;
            last_req = dmi_req_o;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [40:0] act, input logic [40:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic update(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
        dmi_update_i = 1'b1;
        dmi_wdata_i  = {a, d, op};
        tick();
        dmi_update_i = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d, input logic [1:0] r);
        dmi_resp_valid_i = 1'b1;
        dmi_resp_i       = {d, r};
        tick();
        dmi_resp_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        dmi_update_i = 0; dmi_capture_i = 0; dmi_wdata_i = '0;
        dmireset_i = 0; dmihardreset_i = 0;
        dmi_req_ready_i = 0; dmi_resp_i = '0; dmi_resp_valid_i = 0;
        tick(); tick();
        chk("rst_valid", 41'(dmi_req_valid_o), 41'(0));
        chk("rst_rready", 41'(dmi_resp_ready_o), 41'(0));
        chk("rst_rdata", dmi_rdata_o, 41'(0));
        chk("rst_stat", 41'(dmistat_o), 41'(0));
        chk("rst_rstn", 41'(dmi_rst_no), 41'(1));
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_read();
        int c0;
        c0 = req_cnt;
        dmi_req_ready_i = 1'b1;
        update(7'h11, 32'h0, 2'd1);
        chk("rd_valid", 41'(dmi_req_valid_o), 41'(1));
        chk("rd_payload", dmi_req_o, {7'h11, 2'd1, 32'h0});
        tick();
        chk("rd_valid_drop", 41'(dmi_req_valid_o), 41'(0));
        chk("rd_rready", 41'(dmi_resp_ready_o), 41'(1));
        chk("rd_reqcnt", 41'(req_cnt - c0), 41'(1));
        respond(32'hDEADBEEF, 2'd0);
        chk("rd_rready_drop", 41'(dmi_resp_ready_o), 41'(0));
        chk("rd_capture", dmi_rdata_o, {7'h11, 32'hDEADBEEF, 2'd0});
        dmi_capture_i = 1'b1;
        tick();
        dmi_capture_i = 1'b0;
        chk("rd_stat", 41'(dmistat_o), 41'(0));
        dmi_req_ready_i = 1'b0;
    endtask

    task automatic test_write_backpressure();
        int c0;
        c0 = req_cnt;
        dmi_req_ready_i = 1'b0;
        update(7'h04, 32'h12345678, 2'd2);
        for (int i = 0; i < 5; i++) begin
            chk("wr_hold_valid", 41'(dmi_req_valid_o), 41'(1));
            chk("wr_hold_payload", dmi_req_o, {7'h04, 2'd2, 32'h12345678});
            tick();
        end
        chk("wr_no_hs", 41'(req_cnt - c0), 41'(0));
        dmi_req_ready_i = 1'b1;
        tick();
        dmi_req_ready_i = 1'b0;
        chk("wr_one_hs", 41'(req_cnt - c0), 41'(1));
        chk("wr_last_req", last_req, {7'h04, 2'd2, 32'h12345678});
        chk("wr_valid_drop", 41'(dmi_req_valid_o), 41'(0));
        respond(32'h0000FFFF, 2'd0);
        chk("wr_stat", 41'(dmistat_o), 41'(0));
        chk("wr_rdata", dmi_rdata_o, {7'h04, 32'h12345678, 2'd0});
    endtask

    task automatic test_busy();
        int c0;
        c0 = req_cnt;
        dmi_req_ready_i = 1'b1;
        update(7'h22, 32'h0, 2'd1);
        tick();
        dmi_req_ready_i = 1'b0;
        chk("busy_status", 41'(dmi_rdata_o[1:0]), 41'(3));
        dmi_capture_i = 1'b1;
        tick();
        dmi_capture_i = 1'b0;
        chk("busy_stat", 41'(dmistat_o), 41'(3));
        update(7'h33, 32'h0, 2'd1);
        chk("busy_noreq_valid", 41'(dmi_req_valid_o), 41'(0));
        respond(32'hCAFE0001, 2'd0);
        chk("busy_rdata", dmi_rdata_o, {7'h22, 32'hCAFE0001, 2'd3});
        chk("busy_reqcnt", 41'(req_cnt - c0), 41'(1));
        update(7'h44, 32'h0, 2'd1);
        chk("busy_ignored", 41'(dmi_req_valid_o), 41'(0));
        chk("busy_addr_kept", 41'(dmi_rdata_o[40:34]), 41'(7'h22));
        dmireset_i = 1'b1;
        tick();
        dmireset_i = 1'b0;
        chk("busy_cleared", 41'(dmistat_o), 41'(0));
        update(7'h44, 32'h0, 2'd1);
        chk("busy_reissue", 41'(dmi_req_valid_o), 41'(1));
        chk("busy_reissue_req", dmi_req_o, {7'h44, 2'd1, 32'h0});
        dmi_req_ready_i = 1'b1;
        tick();
        dmi_req_ready_i = 1'b0;
        respond(32'h00000044, 2'd0);
        chk("busy_final_stat", 41'(dmistat_o), 41'(0));
    endtask

    task automatic test_failed_resp();
        int c0;
        dmi_req_ready_i = 1'b1;
        update(7'h05, 32'hAAAA5555, 2'd2);
        tick();
        dmi_req_ready_i = 1'b0;
        respond(32'h0, 2'd2);
        chk("fail_stat", 41'(dmistat_o), 41'(2));
        c0 = req_cnt;
        dmi_req_ready_i = 1'b1;
        update(7'h06, 32'h0, 2'd1);
        chk("fail_noreq", 41'(dmi_req_valid_o), 41'(0));
        tick();
        chk("fail_reqcnt", 41'(req_cnt - c0), 41'(0));
        dmi_req_ready_i = 1'b0;
        dmireset_i = 1'b1;
        tick();
        dmireset_i = 1'b0;
        chk("fail_cleared", 41'(dmistat_o), 41'(0));
    endtask

    task automatic test_hardreset();
        dmi_req_ready_i = 1'b0;
        update(7'h07, 32'h00000001, 2'd2);
        chk("hr_valid", 41'(dmi_req_valid_o), 41'(1));
        dmi_capture_i = 1'b1;
        tick();
        dmi_capture_i = 1'b0;
        chk("hr_busy", 41'(dmistat_o), 41'(3));
        dmihardreset_i = 1'b1;
        tick();
        dmihardreset_i = 1'b0;
        chk("hr_valid_drop", 41'(dmi_req_valid_o), 41'(0));
        chk("hr_rstn_low", 41'(dmi_rst_no), 41'(0));
        chk("hr_stat", 41'(dmistat_o), 41'(0));
        chk("hr_idle", 41'(dmi_rdata_o[1:0]), 41'(0));
        tick();
        chk("hr_rstn_high", 41'(dmi_rst_no), 41'(1));
    endtask

    task automatic test_async_reset();
        dmi_req_ready_i = 1'b1;
        update(7'h12, 32'h0, 2'd1);
        tick();
        dmi_req_ready_i = 1'b0;
        chk("ar_waitread", 41'(dmi_resp_ready_o), 41'(1));
        #2 rst_ni = 1'b0;
        #1;
        chk("ar_rready", 41'(dmi_resp_ready_o), 41'(0));
        chk("ar_valid", 41'(dmi_req_valid_o), 41'(0));
        chk("ar_rdata", dmi_rdata_o, 41'(0));
        chk("ar_stat", 41'(dmistat_o), 41'(0));
        chk("ar_rstn", 41'(dmi_rst_no), 41'(1));
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_backpressure();
        test_busy();
        test_failed_resp();
        test_hardreset();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
